execute_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit on the execute side of the decode/execute pipeline register. It consumes the operand bundle presented by that register (rs1/rs2 data, rd, funct3) and computes the result over multiple cycles. While it computes, it holds the front of the pipeline with a stall request. It then returns a one-cycle completion pulse with the result and destination register for the execute/memory path.

---
 rtl/execute_muldiv_unit.sv | 201 ++++++++++++++++++++
 tb/tb_execute_muldiv_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit at the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle.
module execute_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [63:0] r_prod;
  logic [31:0] r_rem;
  logic [31:0] r_opb;
  logic [1:0]  r_f3;
  logic [4:0]  r_rd;
  logic        r_neg;
  logic        r_neg_r;
  logic        r_valid;
  logic [31:0] r_result;
  logic [4:0]  r_rd_out;

  logic        w_accept;
  logic        w_load;
  logic [31:0] w_res;
  logic        w_mul_op;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div0;
  logic        w_ovf;
  logic        w_special;
  logic [31:0] w_spec_res;

  logic [32:0] w_mul_sum;
  logic [63:0] w_prod_nxt;
  logic [63:0] w_prod_fin;
  logic [32:0] w_rem_sh;
  logic [32:0] w_rem_sub;
  logic        w_qbit;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_quo_fin;
  logic [31:0] w_rem_fin;

  assign w_mul_op   = ~i_funct3[2];
  assign w_a_signed = w_mul_op ? (i_funct3[1:0] != 2'b11)
                               : ~i_funct3[0];
  assign w_b_signed = w_mul_op ? ~i_funct3[1] : ~i_funct3[0];
  assign w_a_neg    = w_a_signed & i_rs1_data[31];
  assign w_b_neg    = w_b_signed & i_rs2_data[31];
  assign w_a_mag    = w_a_neg ? (32'd0 - i_rs1_data) : i_rs1_data;
  assign w_b_mag    = w_b_neg ? (32'd0 - i_rs2_data) : i_rs2_data;

  // Divide corner cases resolve at accept, bypassing iteration.
  assign w_div0    = (i_rs2_data == 32'd0);
  assign w_ovf     = ~i_funct3[0]
                   & (i_rs1_data == 32'h8000_0000)
                   & (i_rs2_data == 32'hFFFF_FFFF);
  assign w_special = i_funct3[2] & (w_div0 | w_ovf);
  always_comb begin
    w_spec_res = 32'd0;
    if (i_funct3[1]) begin
      w_spec_res = w_div0 ? i_rs1_data : 32'd0;
    end else begin
      w_spec_res = w_div0 ? 32'hFFFF_FFFF : 32'h8000_0000;
    end
  end

  assign w_mul_sum  = {1'b0, r_prod[63:32]}
                    + (r_prod[0] ? {1'b0, r_opb} : 33'd0);
  assign w_prod_nxt = {w_mul_sum, r_prod[31:1]};
  assign w_prod_fin = r_neg ? (64'd0 - w_prod_nxt) : w_prod_nxt;

  assign w_rem_sh  = {r_rem, r_prod[31]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_opb};
  assign w_qbit    = ~w_rem_sub[32];
  assign w_rem_nxt = w_qbit ? w_rem_sub[31:0] : w_rem_sh[31:0];
  assign w_quo_nxt = {r_prod[30:0], w_qbit};
  assign w_quo_fin = r_neg ? (32'd0 - w_quo_nxt) : w_quo_nxt;
  assign w_rem_fin = r_neg_r ? (32'd0 - w_rem_nxt) : w_rem_nxt;

  assign w_accept = (r_state == S_IDLE) & i_valid & ~i_flush;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_res  = 32'd0;
    o_busy = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          o_busy = 1'b1;
          if (w_mul_op) begin
            w_next = S_MUL;
          end else if (w_special) begin
            w_next = S_DONE;
            w_load = 1'b1;
            w_res  = w_spec_res;
          end else begin
            w_next = S_DIV;
          end
        end
      end
      S_MUL: begin
        o_busy = 1'b1;
        if (r_cnt == 5'd31) begin
          w_next = S_DONE;
          w_load = 1'b1;
          w_res  = (r_f3 == 2'b00) ? w_prod_fin[31:0]
                                   : w_prod_fin[63:32];
        end
      end
      S_DIV: begin
        o_busy = 1'b1;
        if (r_cnt == 5'd31) begin
          w_next = S_DONE;
          w_load = 1'b1;
          w_res  = r_f3[1] ? w_rem_fin : w_quo_fin;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (i_flush) begin
      w_next = S_IDLE;
      w_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_prod   <= 64'd0;
      r_rem    <= 32'd0;
      r_opb    <= 32'd0;
      r_f3     <= 2'd0;
      r_rd     <= 5'd0;
      r_neg    <= 1'b0;
      r_neg_r  <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= 32'd0;
      r_rd_out <= 5'd0;
    end else begin
      r_state <= w_next;
      r_valid <= w_load;
      if (w_load) begin
        r_result <= w_res;
        r_rd_out <= (r_state == S_IDLE) ? i_rd : r_rd;
      end
      if (w_accept) begin
        r_f3    <= i_funct3[1:0];
        r_rd    <= i_rd;
        r_opb   <= w_b_mag;
        r_prod  <= {32'd0, w_a_mag};
        r_rem   <= 32'd0;
        r_cnt   <= 5'd0;
        r_neg   <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end else if (r_state == S_MUL) begin
        r_prod <= w_prod_nxt;
        if (r_cnt != 5'd31) r_cnt <= r_cnt + 5'd1;
      end else if (r_state == S_DIV) begin
        r_rem         <= w_rem_nxt;
        r_prod[31:0]  <= w_quo_nxt;
        if (r_cnt != 5'd31) r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_rd     = r_rd_out;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed bench for execute_muldiv_unit.
// Checks results, latency, stall, flush and reset behaviour.
module tb_execute_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [4:0]  i_rd;
  logic        i_flush;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_rd;

  int n_chk;
  int n_err;

  execute_muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_funct3   (i_funct3),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_rd       (i_rd),
    .i_flush    (i_flush),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_result   (o_result),
    .o_rd       (o_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge of DONE.
  task automatic run_op(input string tag,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd,
                        input logic [31:0] exp_res,
                        input int exp_lat,
                        input bit hold);
    int lat;
    int busy_cnt;
    i_valid    = 1'b1;
    i_funct3   = f3;
    i_rs1_data = a;
    i_rs2_data = b;
    i_rd       = rd;
    #1;
    check({tag, ".busyT"}, 32'(o_busy), 32'd1);
    lat = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (!hold) i_valid = 1'b0;
      #1;
      if (o_valid) begin
        lat = n;
        break;
      end
      if (o_busy) busy_cnt++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".busy"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check({tag, ".res"}, o_result, exp_res);
    check({tag, ".rd"}, 32'(o_rd), 32'(rd));
    check({tag, ".busyD"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst        = 1'b1;
    i_valid    = 1'b0;
    i_funct3   = 3'd0;
    i_rs1_data = 32'd0;
    i_rs2_data = 32'd0;
    i_rd       = 5'd0;
    i_flush    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.valid", 32'(o_valid), 32'd0);
    check("rst.result", o_result, 32'd0);
    check("rst.rd", 32'(o_rd), 32'd0);
    check("rst.busy", 32'(o_busy), 32'd0);
    @(negedge clk);

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5,
           32'hFFFF_FFEB, 33, 1'b0);
    @(negedge clk);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,
           32'h4000_0000, 33, 1'b0);
    @(negedge clk);
    run_op("mulhu", 3'b011, 32'h8000_0000, 32'h8000_0000, 5'd7,
           32'h4000_0000, 33, 1'b0);
    @(negedge clk);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,
           32'hFFFF_FFFF, 33, 1'b0);
    @(negedge clk);
    run_op("mulhu2", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,
           32'hFFFF_FFFE, 33, 1'b0);
    @(negedge clk);
    run_op("div0", 3'b100, 32'h64, 32'd0, 5'd10,
           32'hFFFF_FFFF, 1, 1'b0);
    @(negedge clk);
    run_op("remu0", 3'b111, 32'h64, 32'd0, 5'd11,
           32'h64, 1, 1'b0);
    @(negedge clk);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12,
           32'h8000_0000, 1, 1'b0);
    @(negedge clk);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13,
           32'h0, 1, 1'b0);
    @(negedge clk);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd14,
           32'hFFFF_FFFF, 33, 1'b0);
    @(negedge clk);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd15,
           32'hFFFF_FFFD, 33, 1'b0);
    @(negedge clk);
    run_op("divu", 3'b101, 32'hFFFF_FFF9, 32'd2, 5'd16,
           32'h7FFF_FFFC, 33, 1'b0);
    @(negedge clk);
    run_op("remu", 3'b111, 32'd100, 32'd7, 5'd17,
           32'd2, 33, 1'b0);
    @(negedge clk);

    // Flush a DIV at T+10, then start a MUL at T+11.
    begin
      int seen;
      seen = 0;
      i_valid    = 1'b1;
      i_funct3   = 3'b100;
      i_rs1_data = 32'd1000;
      i_rs2_data = 32'd3;
      i_rd       = 5'd20;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        if (o_valid) seen++;
      end
      i_flush = 1'b1;
      @(negedge clk);
      i_flush = 1'b0;
      #1;
      if (o_valid) seen++;
      check("flush.novalid", 32'(seen), 32'd0);
      check("flush.busy", 32'(o_busy), 32'd0);
      check("flush.res", o_result, 32'd2);
      check("flush.rd", 32'(o_rd), 5'd17);
    end
    run_op("mulaf", 3'b000, 32'd12345, 32'd678, 5'd21,
           32'd8369910, 33, 1'b0);

    // i_valid held through DONE must not restart the unit.
    @(negedge clk);
    run_op("hold", 3'b000, 32'd9, 32'd9, 5'd22, 32'd81, 33, 1'b1);
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    #1;
    check("hold.busy", 32'(o_busy), 32'd0);
    check("hold.valid", 32'(o_valid), 32'd0);

    // Reset mid-operation clears outputs.
    i_valid    = 1'b1;
    i_funct3   = 3'b000;
    i_rs1_data = 32'd3;
    i_rs2_data = 32'd4;
    i_rd       = 5'd3;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid.busy", 32'(o_busy), 32'd0);
    check("rstmid.res", o_result, 32'd0);
    check("rstmid.rd", 32'(o_rd), 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (o_valid) seen++;
      end
      check("rstmid.novalid", 32'(seen), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
